// File: rtl/priv_trap_redirect.sv
// priv_trap_redirect: takes trap requests and MRET/SRET returns from the
// privilege block, computes the redirect PC from tvec/epc/cause, waits for the
// pipeline to drain, then issues a single-cycle insert_pc to fetch.
//
// Optional feature macro: VECTORED_TRAP_EN
//   defined   - mode-1 tvec with an interrupt cause adds (cause << VEC_SHIFT)
//   undefined - every trap goes to the tvec base; no offset adder exists
module priv_trap_redirect #(
    parameter int WORD_W    = 32,
    parameter int VEC_SHIFT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              intr,
    input  logic              intr_to_s,
    input  logic              mret,
    input  logic              sret,
    input  logic              pipe_clear,
    input  logic [WORD_W-1:0] curr_mtvec,
    input  logic [WORD_W-1:0] curr_stvec,
    input  logic [WORD_W-1:0] curr_mepc,
    input  logic [WORD_W-1:0] curr_sepc,
    input  logic [WORD_W-1:0] next_mcause,
    input  logic [WORD_W-1:0] next_scause,
    output logic              insert_pc,
    output logic [WORD_W-1:0] priv_pc,
    output logic              redirect_busy
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_WAIT_CLEAR = 2'b01,
        S_ISSUE      = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                trap_q, trap_d;       // 1: latched request is a trap
    logic [WORD_W-1:0]   target_q, target_d;
    logic [WORD_W-1:0]   priv_pc_q, priv_pc_d;
    logic                insert_q, insert_d;
    logic                busy_q, busy_d;

    logic [WORD_W-1:0]   trap_tvec_s;
    logic [WORD_W-1:0]   trap_cause_s;
    logic [WORD_W-1:0]   trap_target_s;
    logic [WORD_W-1:0]   ret_target_s;

    // Trap target from a tvec value and a cause value.
    function automatic logic [WORD_W-1:0] calc_trap_target(
        input logic [WORD_W-1:0] tvec,
        input logic [WORD_W-1:0] cause
    );
        logic [WORD_W-1:0] base;
        logic [WORD_W-1:0] offset;
        base = {tvec[WORD_W-1:2], 2'b00};
`ifdef VECTORED_TRAP_EN
        offset = {1'b0, cause[WORD_W-2:0]} << VEC_SHIFT;
        if ((tvec[1:0] == 2'b01) && cause[WORD_W-1]) begin
            calc_trap_target = base + offset;   // wrap-around is discarded
        end else begin
            calc_trap_target = base;
        end
`else
        // Mode and cause are ignored in this build; the zero mask keeps the
        // port set identical across builds and folds away to nothing.
        offset = {WORD_W{1'b0}} & (cause << VEC_SHIFT)
                 & {{(WORD_W-2){1'b0}}, tvec[1:0]};
        calc_trap_target = base | offset;
`endif
    endfunction

    // Select the trap CSR set and compute both candidate targets.
    always_comb begin
        trap_tvec_s   = intr_to_s ? curr_stvec  : curr_mtvec;
        trap_cause_s  = intr_to_s ? next_scause : next_mcause;
        trap_target_s = calc_trap_target(trap_tvec_s, trap_cause_s);
        if (mret) begin
            ret_target_s = {curr_mepc[WORD_W-1:1], 1'b0};
        end else begin
            ret_target_s = {curr_sepc[WORD_W-1:1], 1'b0};
        end
    end

    // Next-state, latch-update and registered-output decode.
    always_comb begin
        state_d   = state_q;
        trap_d    = trap_q;
        target_d  = target_q;
        priv_pc_d = priv_pc_q;
        case (state_q)
            S_IDLE: begin
                if (intr || mret || sret) begin
                    if (intr) begin
                        trap_d   = 1'b1;
                        target_d = trap_target_s;
                    end else begin
                        trap_d   = 1'b0;
                        target_d = ret_target_s;
                    end
                    state_d = pipe_clear ? S_ISSUE : S_WAIT_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_CLEAR: begin
                // A trap preempts a pending return; the first trap wins.
                if (intr && !trap_q) begin
                    trap_d   = 1'b1;
                    target_d = trap_target_s;
                end else begin
                    trap_d   = trap_q;
                end
                state_d = pipe_clear ? S_ISSUE : S_WAIT_CLEAR;
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_ISSUE) begin
            priv_pc_d = target_d;
        end else begin
            priv_pc_d = priv_pc_q;
        end
        insert_d = (state_d == S_ISSUE);
        busy_d   = (state_d == S_WAIT_CLEAR);
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            trap_q    <= 1'b0;
            target_q  <= {WORD_W{1'b0}};
            priv_pc_q <= {WORD_W{1'b0}};
            insert_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            target_q  <= target_d;
            priv_pc_q <= priv_pc_d;
            insert_q  <= insert_d;
            busy_q    <= busy_d;
        end
    end

    assign insert_pc     = insert_q;
    assign priv_pc       = priv_pc_q;
    assign redirect_busy = busy_q;

endmodule

// File: tb/tb_priv_trap_redirect.sv
// Directed testbench for priv_trap_redirect with hand-computed expectations.
module tb_priv_trap_redirect;

    logic        CLK = 1'b0;
    logic        RST;
    logic        intr, intr_to_s, mret, sret, pipe_clear;
    logic [31:0] curr_mtvec, curr_stvec, curr_mepc, curr_sepc;
    logic [31:0] next_mcause, next_scause;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        redirect_busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    priv_trap_redirect #(.WORD_W(32), .VEC_SHIFT(2)) dut (
        .CLK(CLK), .RST(RST),
        .intr(intr), .intr_to_s(intr_to_s), .mret(mret), .sret(sret),
        .pipe_clear(pipe_clear),
        .curr_mtvec(curr_mtvec), .curr_stvec(curr_stvec),
        .curr_mepc(curr_mepc), .curr_sepc(curr_sepc),
        .next_mcause(next_mcause), .next_scause(next_scause),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .redirect_busy(redirect_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        intr = 1'b0; intr_to_s = 1'b0; mret = 1'b0; sret = 1'b0;
    endtask

    // Request is already driven with pipe_clear high: expect a pulse next cycle.
    task automatic issue_now(input string tag, input logic [31:0] exp_pc);
        pipe_clear = 1'b1;
        step();
        check({tag, "_insert"}, {31'd0, insert_pc}, 32'd1);
        check({tag, "_pc"}, priv_pc, exp_pc);
        clear_req();
        pipe_clear = 1'b0;
        step();
        check({tag, "_insert_off"}, {31'd0, insert_pc}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; clear_req(); pipe_clear = 1'b0;
        curr_mtvec = 32'd0; curr_stvec = 32'd0; curr_mepc = 32'd0; curr_sepc = 32'd0;
        next_mcause = 32'd0; next_scause = 32'd0;
        step(); step();
        check("rst_insert", {31'd0, insert_pc}, 32'd0);
        check("rst_busy", {31'd0, redirect_busy}, 32'd0);
        check("rst_pc", priv_pc, 32'd0);
        RST = 1'b0;
        step();

        // Direct exception
        curr_mtvec = 32'h8000_0100; next_mcause = 32'h0000_0002; intr = 1'b1;
        issue_now("exc_direct", 32'h8000_0100);
        step();
        check("exc_single_pulse", {31'd0, insert_pc}, 32'd0);

        // Vectored interrupt
        curr_mtvec = 32'h8000_0101; next_mcause = 32'h8000_0007; intr = 1'b1;
`ifdef VECTORED_TRAP_EN
        issue_now("vec_intr", 32'h8000_011C);
`else
        issue_now("vec_intr", 32'h8000_0100);
`endif

        // Mode 1 but exception cause: base only
        curr_mtvec = 32'h8000_0101; next_mcause = 32'h0000_0002; intr = 1'b1;
        issue_now("vec_exc", 32'h8000_0100);

        // S-mode vectored interrupt
        curr_stvec = 32'h0000_1001; next_scause = 32'h8000_0005;
        intr = 1'b1; intr_to_s = 1'b1;
`ifdef VECTORED_TRAP_EN
        issue_now("s_vec", 32'h0000_1014);
`else
        issue_now("s_vec", 32'h0000_1000);
`endif

        // Wrap-around of vectored target
        curr_mtvec = 32'hFFFF_FFF1; next_mcause = 32'h8000_0008; intr = 1'b1;
`ifdef VECTORED_TRAP_EN
        issue_now("vec_wrap", 32'h0000_0010);
`else
        issue_now("vec_wrap", 32'hFFFF_FFF0);
`endif

        // Wait for clear with SRET; later sepc change must not matter
        curr_sepc = 32'h0000_2003; sret = 1'b1; pipe_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wait_busy%0d", i), {31'd0, redirect_busy}, 32'd1);
            check($sformatf("wait_noins%0d", i), {31'd0, insert_pc}, 32'd0);
            sret = 1'b0;
            curr_sepc = 32'h0000_5555;
            if (i == 3) pipe_clear = 1'b1;
        end
        step();
        check("wait_insert", {31'd0, insert_pc}, 32'd1);
        check("wait_pc", priv_pc, 32'h0000_2002);
        check("wait_busy_off", {31'd0, redirect_busy}, 32'd0);
        pipe_clear = 1'b0;
        step();
        check("wait_insert_off", {31'd0, insert_pc}, 32'd0);
        check("pc_hold", priv_pc, 32'h0000_2002);

        // Preemption of MRET by an S trap; later trap/mret ignored
        curr_mepc = 32'h0000_0100; mret = 1'b1;
        step();
        check("pre_busy", {31'd0, redirect_busy}, 32'd1);
        mret = 1'b0;
        curr_stvec = 32'h0000_4000; next_scause = 32'h0000_0003;
        intr = 1'b1; intr_to_s = 1'b1;
        step();
        check("pre_busy2", {31'd0, redirect_busy}, 32'd1);
        intr_to_s = 1'b0; curr_mtvec = 32'h0000_0200; next_mcause = 32'h0000_0002;
        mret = 1'b1;
        step();
        check("pre_noins", {31'd0, insert_pc}, 32'd0);
        clear_req();
        issue_now("preempt", 32'h0000_4000);
        step();
        check("pre_single_pulse", {31'd0, insert_pc}, 32'd0);

        // Simultaneous intr + mret in IDLE
        curr_mtvec = 32'h0000_0200; curr_mepc = 32'h0000_0300;
        next_mcause = 32'h0000_0002; intr = 1'b1; mret = 1'b1;
        issue_now("intr_over_mret", 32'h0000_0200);

        // MRET alone with odd mepc
        curr_mepc = 32'h0000_0301; mret = 1'b1;
        issue_now("mret_only", 32'h0000_0300);

        // Reset during WAIT_CLEAR drops the request
        curr_sepc = 32'h0000_2003; sret = 1'b1; pipe_clear = 1'b0;
        step();
        check("rstw_busy", {31'd0, redirect_busy}, 32'd1);
        sret = 1'b0; RST = 1'b1;
        step();
        check("rstw_busy_off", {31'd0, redirect_busy}, 32'd0);
        check("rstw_noins", {31'd0, insert_pc}, 32'd0);
        check("rstw_pc", priv_pc, 32'd0);
        RST = 1'b0; pipe_clear = 1'b1;
        step();
        check("rstw_noins2", {31'd0, insert_pc}, 32'd0);
        step();
        check("rstw_noins3", {31'd0, insert_pc}, 32'd0);
        check("rstw_idle", {31'd0, redirect_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
